// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: decides each cycle whether PC/IF/ID advance or
// hold, and where bubbles or a delay-slot squash are inserted.
//
// state    | meaning
// RUN      | normal flow; load-use, annul and new multi-cycle ops are evaluated
// MC_STALL | EX holds a multi-cycle op; the pipeline front is frozen
module pipeline_hazard_ctrl #(
  parameter int unsigned REG_W = 5,
  parameter int unsigned LEN_W = 3,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic             ex_load,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_annul_slot,
  input  logic             ex_mc_start,
  input  logic [LEN_W-1:0] ex_mc_len,
  output logic             pc_enable,
  output logic             ifid_enable,
  output logic             ifid_flush,
  output logic             idex_enable,
  output logic             idex_bubble,
  output logic             exmem_bubble,
  output logic             mc_busy,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic {
    RUN      = 1'b0,
    MC_STALL = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] mc_cnt_q, mc_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic mc_req;
  logic rs1_hit;
  logic rs2_hit;
  logic load_use;
  logic mc_freeze;

  // Lengths 0 and 1 are ordinary single-cycle EX operations.
  assign mc_req    = ex_mc_start && (ex_mc_len > LEN_W'(1));
  assign mc_freeze = (state_q == MC_STALL) || ((state_q == RUN) && mc_req);

  // %g0 is hardwired to zero, so a load targeting it can never be a producer.
  assign rs1_hit  = id_uses_rs1 && (id_rs1 == ex_rd);
  assign rs2_hit  = id_uses_rs2 && (id_rs2 == ex_rd);
  assign load_use = ex_load && (ex_rd != '0) && (rs1_hit || rs2_hit);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= RUN;
      mc_cnt_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      mc_cnt_q    <= mc_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Next-state logic; the cycle that starts the op is already one frozen cycle.
  always_comb begin
    state_d  = state_q;
    mc_cnt_d = mc_cnt_q;
    case (state_q)
      RUN: begin
        if (mc_req) begin
          state_d  = MC_STALL;
          mc_cnt_d = ex_mc_len - LEN_W'(2);
        end
      end
      MC_STALL: begin
        if (mc_cnt_q == '0) begin
          state_d = RUN;
        end else begin
          mc_cnt_d = mc_cnt_q - LEN_W'(1);
        end
      end
      default: begin
        state_d  = RUN;
        mc_cnt_d = '0;
      end
    endcase
  end

  // Output logic, evaluated in priority order: freeze, annul, load-use.
  always_comb begin
    pc_enable    = 1'b1;
    ifid_enable  = 1'b1;
    idex_enable  = 1'b1;
    ifid_flush   = 1'b0;
    idex_bubble  = 1'b0;
    exmem_bubble = 1'b0;
    if (!reset) begin
      pc_enable    = 1'b0;
      ifid_enable  = 1'b0;
      idex_enable  = 1'b0;
      idex_bubble  = 1'b1;
      exmem_bubble = 1'b1;
    end else if (mc_freeze) begin
      pc_enable    = 1'b0;
      ifid_enable  = 1'b0;
      idex_enable  = 1'b0;
      exmem_bubble = 1'b1;
    end else if (ex_annul_slot) begin
      // The dependent instruction is the one being squashed, so load-use is moot.
      ifid_flush = 1'b1;
    end else if (load_use) begin
      pc_enable   = 1'b0;
      ifid_enable = 1'b0;
      idex_bubble = 1'b1;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!pc_enable && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  assign mc_busy     = (state_q == MC_STALL);
  assign stall_count = stall_cnt_q;

endmodule
